// File: rtl/fir_mac_scheduler.sv
// Folded FIR controller: one shared 16x16 multiplier and accumulator, one tap per cycle.
// Define FIR_SAT_EN to clamp the scaled result instead of wrapping it.
module fir_mac_scheduler #(
  parameter int N_TAPS = 19,
  parameter int ACC_W  = 37,
  parameter int SHIFT  = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        flush,
  input  logic        coef_we,
  input  logic [5:0]  coef_addr,
  input  logic [15:0] coef_wdata,
  output logic        coef_err,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  localparam int IW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
  localparam logic [IW-1:0] LAST_TAP = IW'(N_TAPS - 1);
  localparam logic [IW:0]   TAPS_X   = (IW + 1)'(N_TAPS);
  localparam logic [6:0]    TAPS_A   = 7'(N_TAPS);

  state_t state, next_state;
  logic [IW-1:0] wr_ptr, base, k, rd_idx;
  logic [IW:0] diff;
  logic signed [15:0] sample [N_TAPS];
  logic signed [15:0] coef [N_TAPS];
  logic signed [ACC_W-1:0] acc;
  logic signed [31:0] prod;
  logic accept, load, coef_ok;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = MAC;
      end
      MAC: if (k == LAST_TAP) next_state = DONE;
      DONE: begin
        if (!out_valid || out_ready) begin
          load       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign accept  = in_valid && in_ready;
  assign coef_ok = coef_we && (state == IDLE) && !accept && ({1'b0, coef_addr} < TAPS_A);

  // Tap k reads the sample k positions older than the newest one, wrapping around the history.
  assign diff   = {1'b0, base} - {1'b0, k};
  assign rd_idx = (base >= k) ? diff[IW-1:0] : IW'(diff + TAPS_X);
  assign prod   = sample[rd_idx] * coef[k];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      base     <= '0;
      k        <= '0;
      acc      <= '0;
      coef_err <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        sample[i] <= '0;
        coef[i]   <= '0;
      end
    end else begin
      coef_err <= coef_we && !coef_ok;
      if (coef_ok) coef[coef_addr[IW-1:0]] <= coef_wdata;
      if (accept) begin
        sample[wr_ptr] <= in_data;
        base           <= wr_ptr;
        wr_ptr         <= (wr_ptr == LAST_TAP) ? '0 : wr_ptr + 1'b1;
        acc            <= '0;
        k              <= '0;
      end else if (state == IDLE && flush) begin
        wr_ptr <= '0;
        for (int i = 0; i < N_TAPS; i++) sample[i] <= '0;
      end
      if (state == MAC) begin
        acc <= acc + {{(ACC_W - 32){prod[31]}}, prod};
        k   <= (k == LAST_TAP) ? '0 : k + 1'b1;
      end
    end
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
  logic signed [ACC_W-1:0] q;
  assign q = acc >>> SHIFT;
`else
  logic unused_acc_bits;
  assign unused_acc_bits = ^acc;
`endif

  // A new result may load on the same edge the consumer takes the old one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
`ifdef FIR_SAT_EN
      if (q > SAT_MAX) begin
        out_data <= 16'h7fff;
        out_sat  <= 1'b1;
      end else if (q < SAT_MIN) begin
        out_data <= 16'h8000;
        out_sat  <= 1'b1;
      end else begin
        out_data <= q[15:0];
        out_sat  <= 1'b0;
      end
`else
      out_data <= acc[SHIFT+15:SHIFT];
      out_sat  <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench: a 4-tap unscaled instance for function/handshake cases and a default
// 19-tap instance for the DC steady-state case.
module tb_fir_mac_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic in_valid, in_ready, flush, coef_we, coef_err, busy, out_valid, out_ready, out_sat;
  logic [15:0] in_data, coef_wdata, out_data;
  logic [5:0] coef_addr;

  logic d_in_valid, d_in_ready, d_flush, d_coef_we, d_coef_err, d_busy;
  logic d_out_valid, d_out_ready, d_out_sat;
  logic [15:0] d_in_data, d_coef_wdata, d_out_data;
  logic [5:0] d_coef_addr;

  int compared = 0;
  int mismatched = 0;

  fir_mac_scheduler #(.N_TAPS(4), .ACC_W(36), .SHIFT(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  fir_mac_scheduler dut_def (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .flush(d_flush), .coef_we(d_coef_we), .coef_addr(d_coef_addr), .coef_wdata(d_coef_wdata),
    .coef_err(d_coef_err), .busy(d_busy), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .out_sat(d_out_sat)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic writeCoef(input int addr, input int value);
    coef_we    = 1'b1;
    coef_addr  = 6'(addr);
    coef_wdata = 16'(value);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic flushPulse();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic applyStimulus(input int value);
    int w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) checkOutput("accept_timeout", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 16'(value);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic getResult(input string tag, input int expected, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_valid"}, int'(out_valid), 1);
    checkOutput(tag, int'($signed(out_data)), expected);
  endtask

  int lat;
  int imp_in [5]  = '{1, 0, 0, 0, 0};
  int imp_exp [5] = '{1, 2, 3, 4, 0};
  int dcoef [19]  = '{26, 100, 300, 700, 1400, 2500, 4000, 6000, 9000, 19660,
                      9000, 6000, 4000, 2500, 1400, 700, 300, 100, 26};
  logic saw_valid;
  int last_dc;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_data = '0; flush = 1'b0; coef_we = 1'b0; coef_addr = '0;
    coef_wdata = '0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_data = '0; d_flush = 1'b0; d_coef_we = 1'b0; d_coef_addr = '0;
    d_coef_wdata = '0; d_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_sat", int'(out_sat), 0);
    checkOutput("rst_coef_err", int'(coef_err), 0);
    reset = 1'b1;
    @(negedge clk);

    // Impulse response, including accept-to-valid latency of N_TAPS+1 edges.
    for (int i = 0; i < 4; i++) writeCoef(i, i + 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(imp_in[i]);
      getResult($sformatf("impulse%0d", i), imp_exp[i], lat);
      checkOutput($sformatf("impulse%0d_latency", i), lat, 5);
    end

    // Back-pressure: second result waits in DONE while the first is held.
    for (int i = 0; i < 4; i++) writeCoef(i, 1);
    out_ready = 1'b0;
    applyStimulus(100);
    getResult("bp_first", 100, lat);
    applyStimulus(200);
    repeat (8) @(negedge clk);
    checkOutput("bp_busy", int'(busy), 1);
    checkOutput("bp_in_ready", int'(in_ready), 0);
    checkOutput("bp_held_valid", int'(out_valid), 1);
    checkOutput("bp_held_data", int'(out_data), 100);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_second_valid", int'(out_valid), 1);
    checkOutput("bp_second_data", int'(out_data), 300);
    @(negedge clk);
    checkOutput("bp_no_dup", int'(out_valid), 0);

    // History wrap, then flush clears it.
    applyStimulus(7); getResult("wrap0", 307, lat);
    applyStimulus(7); getResult("wrap1", 314, lat);
    applyStimulus(7); getResult("wrap2", 221, lat);
    flushPulse();
    applyStimulus(1); getResult("flush_result", 1, lat);

    // Coefficient guard.
    applyStimulus(0);
    coef_we = 1'b1; coef_addr = 6'd0; coef_wdata = 16'd9;
    @(negedge clk);
    coef_we = 1'b0;
    checkOutput("err_in_mac", int'(coef_err), 1);
    @(negedge clk);
    checkOutput("err_pulse_end", int'(coef_err), 0);
    getResult("guard_mac", 1, lat);
    flushPulse();
    applyStimulus(1); getResult("coef_unchanged", 1, lat);
    writeCoef(5, 77);
    checkOutput("err_bad_addr", int'(coef_err), 1);
    writeCoef(0, 9);
    checkOutput("err_good_write", int'(coef_err), 0);
    flushPulse();
    applyStimulus(1); getResult("coef_new", 9, lat);

    // Reset in the middle of a MAC.
    applyStimulus(5);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_out_data", int'(out_data), 0);
    checkOutput("midrst_in_ready", int'(in_ready), 1);
    saw_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    checkOutput("midrst_no_result", int'(saw_valid), 0);
    writeCoef(0, 5);
    applyStimulus(1); getResult("post_reset", 5, lat);

    // Large products: wrap by default, clamp when saturation is built in.
    for (int i = 0; i < 4; i++) writeCoef(i, 32767);
    flushPulse();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32767);
`ifdef FIR_SAT_EN
      getResult($sformatf("sat%0d", i), 32767, lat);
      checkOutput($sformatf("sat%0d_flag", i), int'(out_sat), 1);
`else
      getResult($sformatf("sat%0d", i), i + 1, lat);
      checkOutput($sformatf("sat%0d_flag", i), int'(out_sat), 0);
`endif
    end

    // Default 19-tap build: DC 16384 with coefficient sum 67712 gives 67712*16384/2^19 = 2116.
    for (int i = 0; i < 19; i++) begin
      d_coef_we = 1'b1; d_coef_addr = 6'(i); d_coef_wdata = 16'(dcoef[i]);
      @(negedge clk);
    end
    d_coef_we = 1'b0;
    @(negedge clk);
    checkOutput("dc_coef_err", int'(d_coef_err), 0);
    last_dc = -1;
    for (int s = 0; s < 19; s++) begin
      int w = 0;
      while (!d_in_ready && w < 60) begin @(negedge clk); w++; end
      d_in_valid = 1'b1; d_in_data = 16'd16384;
      @(negedge clk);
      d_in_valid = 1'b0;
      w = 0;
      while (!d_out_valid && w < 60) begin @(negedge clk); w++; end
      if (!d_out_valid) checkOutput($sformatf("dc_timeout%0d", s), int'(d_out_valid), 1);
      last_dc = int'($signed(d_out_data));
    end
    checkOutput("dc_steady", last_dc, 2116);
    checkOutput("dc_sat", int'(d_out_sat), 0);
    @(negedge clk);
    checkOutput("dc_idle", int'(d_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
- Folded, time-multiplexed controller for the team's 19-tap low-pass FIR.
- Shares one 16x16 signed multiplier and one accumulator across all taps. It sequences one tap per cycle over a circular sample history and a runtime-loadable coefficient file.
- Sits between the sample source (valid/ready) and the output consumer (valid/ready).
- Replaces the fully parallel tap/adder-tree datapath where area matters more than throughput.

Parameters:
- N_TAPS, 19: number of taps; legal range 2..64.
- ACC_W, 37: accumulator width; must be >= 32 + ceil(log2(N_TAPS)).
- SHIFT, 19: output scaling; out_data is taken from acc bits [SHIFT+15:SHIFT].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  scheduler can accept a sample.
- in_data  in  16  signed input sample.
- flush  in  1  clear sample history (honoured in IDLE only).
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  6  tap index; writes with coef_addr >= N_TAPS are ignored.
- coef_wdata  in  16  signed coefficient.
- coef_err  out  1  one-cycle pulse when a write is rejected.
- busy  out  1  high whenever state != IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  16  signed scaled result.
- out_sat  out  1  result was clamped (see Optional Feature).

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, wr_ptr=0, acc=0, k=0.
  - All sample entries and all coefficients cleared to 0.
  - out_valid=0, out_data=0, out_sat=0, coef_err=0, busy=0.
  - A reset mid-MAC aborts the computation; no result is emitted.
- States: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge T:
    - sample[wr_ptr] <= in_data.
    - base <= wr_ptr.
    - wr_ptr <= (wr_ptr+1) mod N_TAPS.
    - acc <= 0, k <= 0, state <= MAC.
  - flush (only when no sample is accepted that cycle): zero all sample entries and set wr_ptr=0.
  - flush coincident with an accepted sample: the accept wins and flush is ignored.
- MAC:
  - in_ready=0.
  - Each edge: acc <= acc + sext(sample[(base-k) mod N_TAPS] * coef[k]); k <= k+1.
  - Tap 0 multiplies the newest sample.
  - After the edge with k==N_TAPS-1: state <= DONE.
  - Full-precision signed arithmetic; no intermediate truncation.
- DONE:
  - If !out_valid || out_ready: load out_data and out_sat, set out_valid=1, state <= IDLE.
  - Otherwise stall in DONE with acc held. This is back-pressure; no data is lost.
- Latency: accept at edge T, MAC accumulates on edges T+1..T+N_TAPS, out_valid is first high after edge T+N_TAPS+1 (if unstalled).
- Throughput: one sample per N_TAPS+2 cycles max.
- Output handshake:
  - out_valid stays high with out_data stable until out_valid && out_ready.
  - It then clears on that edge unless a new result loads on the same edge, in which case out_valid stays 1 with the new data.
- Coefficient writes:
  - Accepted only in IDLE, and only when no sample is accepted that same cycle.
  - Otherwise, or when coef_addr >= N_TAPS: the write is dropped and coef_err pulses the next cycle.
- The history pointer wraps modulo N_TAPS. Before N_TAPS samples have arrived, the missing history contributes the reset value 0.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined:
  - Let q = acc >>> SHIFT (arithmetic).
  - If q > 32767, out_data=32767 and out_sat=1.
  - If q < -32768, out_data=-32768 and out_sat=1.
  - Else out_data=q[15:0] and out_sat=0.
- Undefined: out_data = acc[SHIFT+15:SHIFT] (plain truncation/wrap); out_sat tied 0.

Test Plan (N_TAPS=4, SHIFT=0, ACC_W=36 unless stated):
- Impulse response: coefs {1,2,3,4}, feed samples 1,0,0,0,0 with out_ready=1 -> out_data sequence 1,2,3,4,0; each out_valid exactly 5 cycles after its accept edge.
- Back-pressure: coefs {1,1,1,1}, samples 100,200, out_ready=0 -> first result 100 held stable, second computation stalls in DONE (busy=1, in_ready=0); raise out_ready -> 100 then 300 delivered, no loss or duplication.
- Coefficient guard: coef_we during MAC -> coef_err pulses and the coefficient is unchanged; coef_addr=5 in IDLE -> coef_err pulses; valid IDLE write then impulse -> new value observed.
- Flush and reset: after samples 7,7,7, pulse flush in IDLE, then sample 1 with coefs {1,1,1,1} -> out_data=1; assert reset mid-MAC -> no out_valid, outputs 0, next impulse correct.
- Saturation (FIR_SAT_EN defined): coefs all 32767, 4 samples of 32767 -> out_data=32767, out_sat=1; same stimulus without the macro -> out_data = low 16 bits of 4*32767^2 (0x0004), out_sat=0.
- Default config (N_TAPS=19, SHIFT=19, symmetric low-pass coefs 26..19660): DC input 16384 -> steady-state out_data = floor(16384*sum(coefs)/2^19), checked after 19 samples.
